// File: rtl/r5p_soc_memory_copier_if.sv
// TCB-Lite bus bundle shared by a manager and its memory subordinates.
// Request fields travel with vld, and a transfer (trn) happens when vld and rdy are both high.
// The response (rdt/err) follows the transfer by DLY cycles.
interface tcb_lite_if #(
    parameter int unsigned MOD = 1,
    parameter int unsigned ADR = 32,
    parameter int unsigned DAT = 32,
    parameter int unsigned DLY = 1
)(
    input logic clk,
    input logic rst
);

    typedef struct packed {
        logic             ren;
        logic             wen;
        logic [ADR-1:0]   adr;
        logic [DAT/8-1:0] byt;
        logic [DAT-1:0]   wdt;
    } req_t;

    typedef struct packed {
        logic [DAT-1:0] rdt;
        logic           err;
    } rsp_t;

    logic vld;
    logic rdy;
    logic trn;
    req_t req;
    rsp_t rsp;

    assign trn = vld & rdy;

    modport man (input clk, rst, rdy, trn, rsp, output vld, req);
    modport sub (input clk, rst, vld, req, trn, output rdy, rsp);

endinterface

// File: rtl/r5p_soc_memory_copier.sv
// Word-by-word memory copier acting as a TCB-Lite manager.
// Each word is read, captured in a register and then written, so one port serves both regions.
// Start with a single-cycle pulse. The block reports busy, a one-cycle done pulse, a sticky err flag
// and the number of words written so far.
//
// state  | meaning
// -------+----------------------------------------------------
// IDLE   | waiting for start; request fields held at 0
// RD_REQ | read request at the source address, held until rdy
// RD_RSP | read data/err arrive; data captured
// WR_REQ | write request of captured data at the destination
// WR_RSP | write err arrives; count/addresses advance
module r5p_soc_memory_copier #(
    parameter int unsigned CNW = 16,
    parameter int unsigned ADR = 32
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [ADR-1:0] src,
    input  logic [ADR-1:0] dst,
    input  logic [CNW-1:0] len,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [CNW-1:0] cnt,
    tcb_lite_if.man        man
);

    // The data path is fixed at 32-bit memory mode with one cycle of response latency.
    if (man.MOD != 1 || man.DAT != 32 || man.DLY != 1 || man.ADR != ADR) begin : g_param_check
        $fatal(1, "r5p_soc_memory_copier: needs MOD=1, DAT=32, DLY=1 and matching ADR");
    end

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RSP,
        WR_REQ,
        WR_RSP
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [ADR-1:0] adr_src;
    logic [ADR-1:0] adr_dst;
    logic [CNW-1:0] len_r;
    logic [31:0]    dat;
    logic [CNW-1:0] cnt_add;
    logic           fin;
    logic           err_set;
    logic           cnt_inc;
    logic           go;
    logic           go_zero;

    assign busy    = (state != IDLE);
    assign cnt_add = cnt + CNW'(1);
    assign go      = (state == IDLE) && start && (len != '0);
    assign go_zero = (state == IDLE) && start && (len == '0);

    // Next-state decode and request drive; request fields are zero outside the request states.
    always_comb begin
        state_nxt = state;
        man.vld   = 1'b0;
        man.req   = '0;
        fin       = 1'b0;
        err_set   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (go) state_nxt = RD_REQ;
            end
            RD_REQ: begin
                man.vld     = 1'b1;
                man.req.ren = 1'b1;
                man.req.adr = adr_src;
                man.req.byt = 4'b1111;
                if (man.rdy) state_nxt = RD_RSP;
            end
            RD_RSP: begin
                if (man.rsp.err) begin
                    err_set   = 1'b1;
                    fin       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WR_REQ;
                end
            end
            WR_REQ: begin
                man.vld     = 1'b1;
                man.req.wen = 1'b1;
                man.req.adr = adr_dst;
                man.req.byt = 4'b1111;
                man.req.wdt = dat;
                if (man.rdy) state_nxt = WR_RSP;
            end
            WR_RSP: begin
                if (man.rsp.err) begin
                    err_set   = 1'b1;
                    fin       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                    if (cnt_add == len_r) begin
                        fin       = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RD_REQ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, parameter latches, data capture and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            adr_src <= '0;
            adr_dst <= '0;
            len_r   <= '0;
            dat     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= fin || go_zero;
            if (go || go_zero) begin
                cnt <= '0;
                err <= 1'b0;
            end
            if (go) begin
                // Low address bits are forced to zero so every access is word aligned.
                adr_src <= src & ~ADR'(3);
                adr_dst <= dst & ~ADR'(3);
                len_r   <= len;
            end
            if (state == RD_RSP) dat <= man.rsp.rdt;
            if (err_set) err <= 1'b1;
            if (cnt_inc) begin
                cnt     <= cnt_add;
                adr_src <= adr_src + ADR'(4);
                adr_dst <= adr_dst + ADR'(4);
            end
        end
    end

endmodule

// File: tb/tb_r5p_soc_memory_copier.sv
// Directed bench for the memory copier with a word-addressed memory subordinate model.
module tb_r5p_soc_memory_copier;

    localparam int CNW = 16;
    localparam int ADR = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [ADR-1:0] src = '0;
    logic [ADR-1:0] dst = '0;
    logic [CNW-1:0] len = '0;
    logic           busy;
    logic           done;
    logic           err;
    logic [CNW-1:0] cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tcb_lite_if #(.MOD(1), .ADR(ADR), .DAT(32), .DLY(1)) man (.clk(clk), .rst(rst));

    r5p_soc_memory_copier #(.CNW(CNW), .ADR(ADR)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .src   (src),
        .dst   (dst),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .cnt   (cnt),
        .man   (man)
    );

    // subordinate model state
    logic [31:0]    mem [0:16383];
    int             rdy_mode = 0;
    logic           err_en = 1'b0;
    logic [ADR-1:0] err_adr = '0;
    logic [15:0]    rdy_pat;
    int             rdy_idx = 0;
    int             trn_cnt = 0;
    int             vld_cnt = 0;
    int             stall_cnt = 0;
    int             stab_viol = 0;
    int             align_viol = 0;
    int             byt_viol = 0;
    int             bd_viol = 0;
    logic           prev_stall = 1'b0;
    logic [53:0]    prev_req = '0;
    logic [ADR-1:0] rd_log [$];
    logic [ADR-1:0] wr_log [$];

    // rdy changes on the falling edge: always high, or a fixed pseudo-random ~50% pattern
    always @(negedge clk) begin
        rdy_pat = 16'b1011_0010_1100_1010;
        if (rdy_mode == 0) begin
            man.rdy = 1'b1;
        end else begin
            man.rdy = rdy_pat[rdy_idx[3:0]];
            rdy_idx = rdy_idx + 1;
        end
    end

    // memory subordinate with one-cycle response, plus protocol observers
    always @(posedge clk) begin
        if (rst) begin
            man.rsp    <= '0;
            prev_stall <= 1'b0;
        end else begin
            if (man.vld) begin
                vld_cnt <= vld_cnt + 1;
                if (man.req.adr[1:0] != 2'b00) align_viol <= align_viol + 1;
                if (man.req.byt != 4'hf) byt_viol <= byt_viol + 1;
            end
            if (prev_stall && (!man.vld || man.req !== prev_req)) stab_viol <= stab_viol + 1;
            prev_stall <= man.vld && !man.rdy;
            prev_req   <= man.req;
            if (man.vld && !man.rdy) stall_cnt <= stall_cnt + 1;
            if (done && busy) bd_viol <= bd_viol + 1;
            man.rsp <= '0;
            if (man.trn) begin
                trn_cnt <= trn_cnt + 1;
                if (man.req.wen) begin
                    mem[man.req.adr[15:2]] = man.req.wdt;
                    wr_log.push_back(man.req.adr);
                end
                if (man.req.ren) begin
                    rd_log.push_back(man.req.adr);
                    man.rsp.rdt <= mem[man.req.adr[15:2]];
                    man.rsp.err <= err_en && (man.req.adr == err_adr);
                end
            end
        end
    end

    // stimulus helpers (no checking): pulse start, then count cycles until done
    task automatic kick(input logic [ADR-1:0] s, input logic [ADR-1:0] d, input logic [CNW-1:0] n);
        @(posedge clk); #1;
        src = s; dst = d; len = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, inout int cyc);
        while (!done && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic load_src();
        mem[16'h100 >> 2] = 32'h11111111;
        mem[16'h104 >> 2] = 32'h22222222;
        mem[16'h108 >> 2] = 32'h33333333;
        mem[16'h10c >> 2] = 32'h44444444;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, err} !== 3'b000) begin
            fails++; $display("FAIL reset_status: got busy/done/err=%b expected 000", {busy, done, err});
        end
        tests++;
        if (cnt !== '0) begin
            fails++; $display("FAIL reset_cnt: got %0d expected 0", cnt);
        end
        tests++;
        if ({man.vld, man.req} !== 55'd0) begin
            fails++; $display("FAIL reset_req: got vld=%b req=%h expected all zero", man.vld, man.req);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        int t0;
        load_src();
        for (int i = 0; i < 4; i++) mem[(16'h200 >> 2) + i] = '0;
        rdy_mode = 0;
        t0 = trn_cnt;
        kick(16'h100, 16'h200, 4);
        cyc = 1;
        tests++;
        if (!(busy === 1'b1 && man.vld === 1'b1 && man.req.ren === 1'b1 && man.req.adr === 16'h100)) begin
            fails++; $display("FAIL basic_first_req: got busy=%b vld=%b ren=%b adr=%h expected 1 1 1 0100",
                              busy, man.vld, man.req.ren, man.req.adr);
        end
        wait_done(100, cyc);
        tests++;
        if (done !== 1'b1 || cyc != 17) begin
            fails++; $display("FAIL basic_done_cycle: got done=%b at cycle %0d expected done=1 at 17", done, cyc);
        end
        tests++;
        if (busy !== 1'b0 || cnt !== 16'd4 || err !== 1'b0) begin
            fails++; $display("FAIL basic_status: got busy=%b cnt=%0d err=%b expected 0 4 0", busy, cnt, err);
        end
        tests++;
        if (trn_cnt - t0 != 8) begin
            fails++; $display("FAIL basic_transfers: got %0d expected 8", trn_cnt - t0);
        end
        tests++;
        if (mem[16'h200 >> 2] !== 32'h11111111 || mem[16'h204 >> 2] !== 32'h22222222 ||
            mem[16'h208 >> 2] !== 32'h33333333 || mem[16'h20c >> 2] !== 32'h44444444) begin
            fails++; $display("FAIL basic_data: got %h %h %h %h expected 11111111..44444444",
                              mem[16'h200 >> 2], mem[16'h204 >> 2], mem[16'h208 >> 2], mem[16'h20c >> 2]);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0) begin
            fails++; $display("FAIL basic_done_pulse: got done=%b one cycle later expected 0", done);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        int s0;
        int v0;
        for (int i = 0; i < 4; i++) mem[(16'h200 >> 2) + i] = '0;
        s0 = stall_cnt;
        v0 = stab_viol;
        rdy_mode = 1;
        kick(16'h100, 16'h200, 4);
        cyc = 1;
        wait_done(400, cyc);
        rdy_mode = 0;
        tests++;
        if (done !== 1'b1 || cyc != 17 + (stall_cnt - s0)) begin
            fails++; $display("FAIL bp_latency: got done=%b at cycle %0d expected done=1 at %0d",
                              done, cyc, 17 + (stall_cnt - s0));
        end
        tests++;
        if (stall_cnt - s0 == 0) begin
            fails++; $display("FAIL bp_stalls: got 0 stall cycles expected some");
        end
        tests++;
        if (stab_viol - v0 != 0) begin
            fails++; $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stab_viol - v0);
        end
        tests++;
        if (cnt !== 16'd4 || mem[16'h200 >> 2] !== 32'h11111111 || mem[16'h20c >> 2] !== 32'h44444444) begin
            fails++; $display("FAIL bp_data: got cnt=%0d first=%h last=%h expected 4 11111111 44444444",
                              cnt, mem[16'h200 >> 2], mem[16'h20c >> 2]);
        end
    endtask

    task automatic test_error();
        int cyc;
        for (int i = 0; i < 4; i++) mem[(16'h280 >> 2) + i] = '0;
        wr_log.delete();
        err_en  = 1'b1;
        err_adr = 16'h108;
        kick(16'h100, 16'h280, 4);
        cyc = 1;
        wait_done(100, cyc);
        err_en = 1'b0;
        tests++;
        if (done !== 1'b1 || cyc != 11) begin
            fails++; $display("FAIL err_done: got done=%b at cycle %0d expected done=1 at 11", done, cyc);
        end
        tests++;
        if (err !== 1'b1 || cnt !== 16'd2 || busy !== 1'b0) begin
            fails++; $display("FAIL err_status: got err=%b cnt=%0d busy=%b expected 1 2 0", err, cnt, busy);
        end
        tests++;
        if (wr_log.size() != 2 || mem[16'h288 >> 2] !== 32'h0) begin
            fails++; $display("FAIL err_no_write: got %0d writes, dst+8=%h expected 2 writes, 00000000",
                              wr_log.size(), mem[16'h288 >> 2]);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (err !== 1'b1) begin
            fails++; $display("FAIL err_sticky: got err=%b expected 1", err);
        end
        kick(16'h100, 16'h280, 1);
        tests++;
        if (err !== 1'b0) begin
            fails++; $display("FAIL err_clear: got err=%b after start expected 0", err);
        end
        cyc = 1;
        wait_done(100, cyc);
        tests++;
        if (done !== 1'b1 || cyc != 5 || cnt !== 16'd1 || err !== 1'b0) begin
            fails++; $display("FAIL err_retry: got done=%b cyc=%0d cnt=%0d err=%b expected 1 5 1 0",
                              done, cyc, cnt, err);
        end
    endtask

    task automatic test_zero_busy();
        int cyc;
        int v0;
        v0 = vld_cnt;
        kick(16'h100, 16'h200, 0);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || cnt !== '0) begin
            fails++; $display("FAIL zero_done: got done=%b busy=%b cnt=%0d at cycle 1 expected 1 0 0",
                              done, busy, cnt);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || vld_cnt - v0 != 0) begin
            fails++; $display("FAIL zero_no_req: got done=%b vld cycles=%0d expected 0 0", done, vld_cnt - v0);
        end
        for (int i = 0; i < 4; i++) mem[(16'h300 >> 2) + i] = '0;
        for (int i = 0; i < 2; i++) mem[(16'h380 >> 2) + i] = '0;
        rd_log.delete();
        kick(16'h100, 16'h300, 4);
        cyc = 1;
        repeat (4) begin
            @(posedge clk); #1;
            cyc++;
        end
        src = 16'h180; dst = 16'h380; len = 2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
        wait_done(100, cyc);
        tests++;
        if (done !== 1'b1 || cyc != 17 || cnt !== 16'd4) begin
            fails++; $display("FAIL busy_start: got done=%b cyc=%0d cnt=%0d expected 1 17 4", done, cyc, cnt);
        end
        tests++;
        if (rd_log.size() != 4 || rd_log[3] !== 16'h10c || mem[16'h30c >> 2] !== 32'h44444444 ||
            mem[16'h380 >> 2] !== 32'h0) begin
            fails++; $display("FAIL busy_start_data: got reads=%0d dst_last=%h alt=%h expected 4 44444444 00000000",
                              rd_log.size(), mem[16'h30c >> 2], mem[16'h380 >> 2]);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        int a0;
        mem[16'hfffc >> 2] = 32'ha5a5a5a5;
        mem[0]             = 32'h5a5a5a5a;
        mem[16'h400 >> 2]  = '0;
        mem[16'h404 >> 2]  = '0;
        rd_log.delete();
        wr_log.delete();
        a0 = align_viol;
        kick(16'hffff, 16'h0403, 2);
        tests++;
        if (man.req.adr !== 16'hfffc) begin
            fails++; $display("FAIL wrap_first_adr: got %h expected fffc", man.req.adr);
        end
        cyc = 1;
        wait_done(100, cyc);
        tests++;
        if (done !== 1'b1 || cyc != 9 || rd_log.size() != 2 || rd_log[0] !== 16'hfffc || rd_log[1] !== 16'h0000) begin
            fails++; $display("FAIL wrap_reads: got done=%b cyc=%0d n=%0d expected 1 9 2 reads fffc,0000",
                              done, cyc, rd_log.size());
        end
        tests++;
        if (wr_log.size() != 2 || wr_log[0] !== 16'h0400 || wr_log[1] !== 16'h0404 ||
            mem[16'h400 >> 2] !== 32'ha5a5a5a5 || mem[16'h404 >> 2] !== 32'h5a5a5a5a) begin
            fails++; $display("FAIL wrap_writes: got n=%0d data %h %h expected 2 writes a5a5a5a5 5a5a5a5a",
                              wr_log.size(), mem[16'h400 >> 2], mem[16'h404 >> 2]);
        end
        tests++;
        if (align_viol - a0 != 0) begin
            fails++; $display("FAIL wrap_align: got %0d misaligned requests expected 0", align_viol - a0);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int k;
        bit seen;
        for (int i = 0; i < 3; i++) mem[(16'h500 >> 2) + i] = '0;
        kick(16'h100, 16'h200, 4);
        k = 0;
        while (!(man.vld && man.req.wen && man.req.adr == 16'h204) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        tests++;
        if (k >= 50) begin
            fails++; $display("FAIL rstmid_reach: got no write request to 0204 expected one within 50 cycles");
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({busy, done, err, cnt, man.vld, man.req} !== 74'd0) begin
            fails++; $display("FAIL rstmid_values: got busy=%b done=%b err=%b cnt=%0d vld=%b req=%h expected all zero",
                              busy, done, err, cnt, man.vld, man.req);
        end
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++; $display("FAIL rstmid_no_done: got done pulse after reset expected none");
        end
        kick(16'h100, 16'h500, 3);
        cyc = 1;
        wait_done(100, cyc);
        tests++;
        if (done !== 1'b1 || cyc != 13 || cnt !== 16'd3 || mem[16'h500 >> 2] !== 32'h11111111 ||
            mem[16'h508 >> 2] !== 32'h33333333) begin
            fails++; $display("FAIL rstmid_recopy: got done=%b cyc=%0d cnt=%0d d0=%h d2=%h expected 1 13 3 11111111 33333333",
                              done, cyc, cnt, mem[16'h500 >> 2], mem[16'h508 >> 2]);
        end
    endtask

    task automatic test_invariants();
        tests++;
        if (bd_viol != 0 || byt_viol != 0) begin
            fails++; $display("FAIL invariants: got busy&done=%0d bad byt=%0d expected 0 0", bd_viol, byt_viol);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_error();
        test_zero_busy();
        test_wrap();
        test_reset_mid();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
